// File: rtl/conway_pkg.sv
// Shared types for the Game of Life run controller.
// Holds the command, halt-reason and sequencer-state encodings.
// halt_check() picks the halt reason after a generation check; both RUN ticks and STEP use it.
package conway_pkg;

  // Command opcodes carried on cmd_op
  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_RUN   = 2'd1,
    OP_STEP  = 2'd2,
    OP_PAUSE = 2'd3
  } cmd_op_t;

  // Reason for the most recent return to IDLE from RUN/STEP
  typedef enum logic [1:0] {
    HALT_TARGET  = 2'd0,
    HALT_PAUSED  = 2'd1,
    HALT_STABLE  = 2'd2,
    HALT_EXTINCT = 2'd3
  } halt_reason_t;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } seq_state_t;

  localparam int GEN_W_DEFAULT    = 16;
  localparam int PERIOD_W_DEFAULT = 24;

  // Extinction outranks stability. A live, changing grid advances and reports TARGET
  // (the caller decides whether TARGET actually ends the run).
  function automatic halt_reason_t halt_check(input logic alive, input logic changed);
    if (!alive)
      return HALT_EXTINCT;
    else if (!changed)
      return HALT_STABLE;
    else
      return HALT_TARGET;
  endfunction

endpackage

// File: rtl/conway_sequencer_tick_prescaler.sv
// Generation pacing counter: tick is high on the cycle the count equals period.
// Ports: clk, rst (async active-low), clear (hold count at 0, no tick), period, tick.
// The count returns to 0 after every tick, so ticks are period+1 cycles apart (period=0 ticks every cycle).
module tick_prescaler #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] presc;

  assign tick = !clear && (presc == period);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (clear || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/conway_sequencer.sv
// Run controller for the cell array: takes LOAD/RUN/STEP/PAUSE commands, drives grid_rst/grid_ena.
// Ports: cmd_* valid/ready command channel; grid_alive/grid_changed status in; grid_rst/grid_ena out;
//        gen_count, busy, done (one-cycle pulse), halt_reason status out.
// Commands are accepted in IDLE and RUN. grid_* and cmd_ready/busy are decoded from state.
module conway_sequencer
  import conway_pkg::*;
#(
  parameter int GEN_W    = GEN_W_DEFAULT,
  parameter int PERIOD_W = PERIOD_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [GEN_W-1:0]    cmd_count,
  input  logic [PERIOD_W-1:0] period,
  input  logic                grid_alive,
  input  logic                grid_changed,
  output logic                grid_rst,
  output logic                grid_ena,
  output logic [GEN_W-1:0]    gen_count,
  output logic                busy,
  output logic                done,
  output logic [1:0]          halt_reason
);

  seq_state_t          state;
  logic [GEN_W-1:0]    gens_left;
  logic [PERIOD_W-1:0] per_q;
  halt_reason_t        reason_q;

  cmd_op_t op;
  logic    accept;
  logic    tick;
  logic    advance;
  logic    pause_req;
  logic    load_req;
  logic    preempt;

  assign op     = cmd_op_t'(cmd_op);
  assign accept = cmd_valid && cmd_ready;

  // Outside RUN the prescaler is held clear, so a new RUN always starts counting from 0
  tick_prescaler #(
    .PERIOD_W(PERIOD_W)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_RUN),
    .period (per_q),
    .tick   (tick)
  );

  // A generation may only advance when the grid is both alive and still changing
  assign advance = grid_alive && grid_changed;

  // PAUSE or LOAD accepted during RUN leaves RUN this cycle, so it wins over a tick
  assign pause_req = accept && (state == ST_RUN) && (op == OP_PAUSE);
  assign load_req  = accept && (state == ST_RUN) && (op == OP_LOAD);
  assign preempt   = pause_req || load_req;

  assign cmd_ready   = (state == ST_IDLE) || (state == ST_RUN);
  assign busy        = (state != ST_IDLE);
  assign grid_rst    = (state == ST_LOAD);
  assign grid_ena    = ((state == ST_STEP) && advance) ||
                       ((state == ST_RUN) && tick && !preempt && advance);
  assign halt_reason = reason_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      gens_left <= '0;
      per_q     <= '0;
      gen_count <= '0;
      done      <= 1'b0;
      reason_q  <= HALT_TARGET;
    end else begin
      done <= 1'b0;

      // Wraps silently at 2^GEN_W
      if (grid_ena)
        gen_count <= gen_count + 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_LOAD: state <= ST_LOAD;
              OP_RUN: begin
                state     <= ST_RUN;
                gens_left <= cmd_count;
                per_q     <= period;
              end
              OP_STEP: state <= ST_STEP;
              default: state <= ST_IDLE;  // PAUSE while idle is a no-op
            endcase
          end
        end

        ST_LOAD: begin
          gen_count <= '0;
          state     <= ST_IDLE;
        end

        ST_STEP: begin
          state    <= ST_IDLE;
          done     <= 1'b1;
          reason_q <= halt_check(grid_alive, grid_changed);
        end

        ST_RUN: begin
          if (pause_req) begin
            state    <= ST_IDLE;
            done     <= 1'b1;
            reason_q <= HALT_PAUSED;
          end else if (load_req) begin
            state <= ST_LOAD;
          end else if (tick) begin
            if (!advance) begin
              state    <= ST_IDLE;
              done     <= 1'b1;
              reason_q <= halt_check(grid_alive, grid_changed);
            end else if (gens_left == GEN_W'(1)) begin
              state    <= ST_IDLE;
              done     <= 1'b1;
              reason_q <= HALT_TARGET;
            end else if (gens_left != '0) begin
              // A count of 0 means unlimited and is never decremented
              gens_left <= gens_left - 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conway_sequencer.sv
module tb_conway_sequencer;
  import conway_pkg::*;

  localparam int GEN_W    = 4;
  localparam int PERIOD_W = 24;
  localparam int GEN_MOD  = 1 << GEN_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [GEN_W-1:0]    cmd_count;
  logic [PERIOD_W-1:0] period;
  logic                grid_alive;
  logic                grid_changed;
  logic                grid_rst;
  logic                grid_ena;
  logic [GEN_W-1:0]    gen_count;
  logic                busy;
  logic                done;
  logic [1:0]          halt_reason;

  always #5 clk = ~clk;

  conway_sequencer #(
    .GEN_W   (GEN_W),
    .PERIOD_W(PERIOD_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_count   (cmd_count),
    .period      (period),
    .grid_alive  (grid_alive),
    .grid_changed(grid_changed),
    .grid_rst    (grid_rst),
    .grid_ena    (grid_ena),
    .gen_count   (gen_count),
    .busy        (busy),
    .done        (done),
    .halt_reason (halt_reason)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ena_cnt  = 0;
  int rst_cnt  = 0;
  int done_cnt = 0;
  int ena_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode names follow the controller's documented phases; the prescaler is modelled as a
  // countdown to the next generation rather than an up-counter.
  typedef enum int {M_IDLE, M_LOAD, M_RUN, M_STEP} mmode_t;
  mmode_t m_mode   = M_IDLE;
  int     m_to_gen = 0;   // RUN cycles remaining before the next generation cycle
  int     m_per    = 0;
  int     m_left   = 0;
  int     m_gen    = 0;
  int     m_done   = 0;
  int     m_reason = 0;

  function automatic int reason_for(input logic alive, input logic changed);
    if (!alive) return 3;
    if (!changed) return 2;
    return 0;
  endfunction

  always @(negedge clk) begin : cmp
    bit e_ready, e_busy, e_rst, e_ena, acc, gen_cycle, leave;
    cyc++;
    if (!rst) begin
      m_mode = M_IDLE; m_to_gen = 0; m_per = 0; m_left = 0;
      m_gen = 0; m_done = 0; m_reason = 0;
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_grid_rst", grid_rst, 0);
      check("rst_grid_ena", grid_ena, 0);
      check("rst_gen", gen_count, 0);
      check("rst_done", done, 0);
      check("rst_reason", halt_reason, 0);
    end else begin
      e_ready   = (m_mode == M_IDLE) || (m_mode == M_RUN);
      e_busy    = (m_mode != M_IDLE);
      e_rst     = (m_mode == M_LOAD);
      acc       = cmd_valid && e_ready;
      gen_cycle = (m_mode == M_RUN) && (m_to_gen == 0);
      leave     = (m_mode == M_RUN) && acc && (cmd_op == 2'd3 || cmd_op == 2'd0);
      e_ena = ((m_mode == M_STEP) || (gen_cycle && !leave)) && grid_alive && grid_changed;

      check("ready", cmd_ready, e_ready);
      check("busy", busy, e_busy);
      check("grid_rst", grid_rst, e_rst);
      check("grid_ena", grid_ena, e_ena);
      check("gen_count", gen_count, m_gen);
      check("done", done, m_done);
      check("halt_reason", halt_reason, m_reason);

      m_done = 0;
      if (e_ena) m_gen = (m_gen + 1) % GEN_MOD;
      case (m_mode)
        M_IDLE: if (acc) begin
          if (cmd_op == 2'd0) m_mode = M_LOAD;
          else if (cmd_op == 2'd2) m_mode = M_STEP;
          else if (cmd_op == 2'd1) begin
            m_mode = M_RUN; m_left = cmd_count; m_per = period; m_to_gen = period;
          end
        end
        M_LOAD: begin m_gen = 0; m_mode = M_IDLE; end
        M_STEP: begin m_mode = M_IDLE; m_done = 1; m_reason = reason_for(grid_alive, grid_changed); end
        M_RUN: begin
          if (acc && cmd_op == 2'd3) begin
            m_mode = M_IDLE; m_done = 1; m_reason = 1;
          end else if (acc && cmd_op == 2'd0) begin
            m_mode = M_LOAD;
          end else if (gen_cycle) begin
            m_to_gen = m_per;
            if (!(grid_alive && grid_changed)) begin
              m_mode = M_IDLE; m_done = 1; m_reason = reason_for(grid_alive, grid_changed);
            end else if (m_left == 1) begin
              m_mode = M_IDLE; m_done = 1; m_reason = 0;
            end else if (m_left > 0) begin
              m_left--;
            end
          end else begin
            m_to_gen--;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
    if (grid_ena) begin ena_cnt++; ena_cyc.push_back(cyc); end
    if (grid_rst) rst_cnt++;
    if (done) done_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] op, input int cnt, input int per, output int acc_cyc);
    bit got;
    got = 0;
    acc_cyc = 0;
    sync();
    cmd_valid = 1'b1; cmd_op = op; cmd_count = GEN_W'(cnt); period = PERIOD_W'(per);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (cmd_ready) begin got = 1; acc_cyc = cyc; break; end
    end
    if (!got) check("send_timeout", 0, 1);
    sync();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit got;
    got = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (done) begin got = 1; break; end
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  task automatic wait_ena(input int target, input int limit);
    bit got;
    got = 0;
    for (int i = 0; i < limit; i++) begin
      if (ena_cnt >= target) begin got = 1; break; end
      @(negedge clk); #1;
    end
    if (!got) check("ena_timeout", ena_cnt, target);
  endtask

  int c;
  int exp_ena[3] = '{3, 6, 9};

  initial begin
    cmd_valid = 0; cmd_op = 0; cmd_count = 0; period = 0;
    grid_alive = 1; grid_changed = 1;
    #2 rst = 1'b0;
    #1;
    check("init_ready", cmd_ready, 1);
    check("init_busy", busy, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // 1: LOAD then RUN count=3 period=2
    rst_cnt = 0;
    send(2'd0, 0, 0, c);
    repeat (3) @(negedge clk);
    #1 check("load_rst_pulses", rst_cnt, 1);
    ena_cyc.delete(); ena_cnt = 0; done_cnt = 0;
    send(2'd1, 3, 2, c);
    wait_done(50);
    repeat (3) @(negedge clk);
    #1;
    check("t1_ena_count", ena_cnt, 3);
    foreach (ena_cyc[i]) if (i < 3) check("t1_ena_cycle", ena_cyc[i] - c, exp_ena[i]);
    check("t1_gen", gen_count, 3);
    check("t1_done_count", done_cnt, 1);
    check("t1_reason", halt_reason, 0);

    // 2: STEP changing, then STEP stable
    send(2'd0, 0, 0, c);
    ena_cnt = 0;
    send(2'd2, 0, 0, c);
    wait_done(10);
    check("t2a_ena", ena_cnt, 1);
    check("t2a_gen", gen_count, 1);
    check("t2a_reason", halt_reason, 0);
    sync(); grid_changed = 0;
    ena_cnt = 0;
    send(2'd2, 0, 0, c);
    wait_done(10);
    check("t2b_ena", ena_cnt, 0);
    check("t2b_gen", gen_count, 1);
    check("t2b_reason", halt_reason, 2);

    // 3: unlimited run every cycle, extinction after 5 generations
    sync(); grid_changed = 1; grid_alive = 1;
    send(2'd0, 0, 0, c);
    ena_cnt = 0;
    send(2'd1, 0, 0, c);
    wait_ena(5, 50);
    sync(); grid_alive = 0;
    wait_done(10);
    check("t3_reason", halt_reason, 3);
    check("t3_gen", gen_count, 5);
    check("t3_ena", ena_cnt, 5);

    // 4: PAUSE lands exactly on the second tick of period=4
    sync(); grid_alive = 1;
    send(2'd0, 0, 0, c);
    ena_cnt = 0;
    send(2'd1, 0, 4, c);
    for (int i = 0; i < 50; i++) begin
      if (cyc >= c + 9) break;
      @(negedge clk); #1;
    end
    sync(); cmd_valid = 1; cmd_op = 2'd3;
    @(negedge clk); #1;
    check("t4_ena_on_pause", grid_ena, 0);
    check("t4_ena_count", ena_cnt, 1);
    sync(); cmd_valid = 0;
    @(negedge clk); #1;
    check("t4_done", done, 1);
    check("t4_reason", halt_reason, 1);

    // 5: asynchronous reset mid-RUN
    send(2'd0, 0, 0, c);
    send(2'd1, 0, 1, c);
    repeat (6) @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("t5_ena", grid_ena, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", cmd_ready, 1);
    check("t5_gen", gen_count, 0);
    @(negedge clk); #2 rst = 1'b1;
    ena_cnt = 0;
    repeat (10) @(negedge clk);
    #1 check("t5_no_ena_after", ena_cnt, 0);

    // 6: wrap of the 4-bit generation counter, STEP inside RUN dropped
    send(2'd0, 0, 0, c);
    ena_cnt = 0;
    send(2'd1, 0, 0, c);
    wait_ena(8, 50);
    sync(); cmd_valid = 1; cmd_op = 2'd2;
    sync(); cmd_valid = 0;
    check("t6_still_busy", busy, 1);
    wait_ena(17, 50);
    sync(); cmd_valid = 1; cmd_op = 2'd3;
    sync(); cmd_valid = 0;
    @(negedge clk); #1;
    check("t6_done", done, 1);
    check("t6_gen_wrapped", gen_count, 1);
    check("t6_ena", ena_cnt, 17);
    check("t6_reason", halt_reason, 1);

    // 7: randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      sync();
      cmd_valid    = ($urandom % 4) == 0;
      cmd_op       = 2'($urandom % 4);
      cmd_count    = GEN_W'($urandom % 6);
      period       = PERIOD_W'($urandom % 4);
      grid_alive   = ($urandom % 16) != 0;
      grid_changed = ($urandom % 12) != 0;
    end
    sync(); cmd_valid = 0;
    repeat (5) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
